// File: rtl/cu_pkg.sv
// Shared types for the multicycle control unit: FSM states, opcodes,
// writeback-source codes and the decoded control bundle.
package cu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MEM  = 2'd2,
    WB   = 2'd3
  } state_t;

  // Opcodes 0, 3, 6, 7 and 14 are plain ALU operations with no special handling.
  typedef enum logic [3:0] {
    OP_ADD = 4'd1,
    OP_AND = 4'd2,
    OP_NOR = 4'd4,
    OP_SLT = 4'd5,
    OP_J   = 4'd8,
    OP_JAL = 4'd9,
    OP_LW  = 4'd10,
    OP_SW  = 4'd11,
    OP_BEQ = 4'd12,
    OP_BNE = 4'd13,
    OP_LI  = 4'd15
  } opcode_t;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;
  localparam logic [1:0] SEL_IMM  = 2'd3;

  typedef struct packed {
    logic       to_wb;
    logic       to_mem;
    logic       mem_rd;
    logic       mem_wr;
    logic       jump;
    logic       br_eq;
    logic       br_ne;
    logic       wb_rd0;
    logic [1:0] wb_sel;
  } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode-to-control table for the multicycle control unit.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opc,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.to_wb  = 1'b1;
    ctrl.wb_sel = SEL_ALU;
    case (opc)
      OPC_W'(OP_ADD), OPC_W'(OP_AND), OPC_W'(OP_NOR), OPC_W'(OP_SLT): ctrl.wb_rd0 = 1'b1;
      OPC_W'(OP_LI): ctrl.wb_sel = SEL_IMM;
      OPC_W'(OP_J): begin
        ctrl.to_wb = 1'b0;
        ctrl.jump  = 1'b1;
      end
      OPC_W'(OP_JAL): begin
        ctrl.jump   = 1'b1;
        ctrl.wb_sel = SEL_LINK;
      end
      // LW reaches writeback through MEM, so it does not take the direct EXEC->WB path.
      OPC_W'(OP_LW): begin
        ctrl.to_wb  = 1'b0;
        ctrl.to_mem = 1'b1;
        ctrl.mem_rd = 1'b1;
        ctrl.wb_sel = SEL_MEM;
      end
      OPC_W'(OP_SW): begin
        ctrl.to_wb  = 1'b0;
        ctrl.to_mem = 1'b1;
        ctrl.mem_wr = 1'b1;
      end
      OPC_W'(OP_BEQ): begin
        ctrl.to_wb = 1'b0;
        ctrl.br_eq = 1'b1;
      end
      OPC_W'(OP_BNE): begin
        ctrl.to_wb = 1'b0;
        ctrl.br_ne = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM (IDLE/EXEC/MEM/WB) driving datapath strobes.
// Define MULTICYCLE_CONTROL_MEM_TIMEOUT_EN to abort MEM waits after TIMEOUT cycles.
module multicycle_control
  import cu_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int OPC_W   = 4,
  parameter int RA_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               alu_zero,
  input  logic               mem_ack,
  output logic               mem_r_en,
  output logic               mem_w_en,
  output logic               reg_w_en,
  output logic               pc_load,
  output logic [1:0]         sel_w_source,
  output logic [OPC_W-1:0]   alu_op,
  output logic [RA_W-1:0]    reg_addr_0,
  output logic [RA_W-1:0]    reg_addr_1,
  output logic [RA_W-1:0]    reg_addr_w,
  output logic               done,
  output logic               err
);

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] instr_q;
  logic [OPC_W-1:0]   opc;
  ctrl_t              ctrl;
  logic               retire;
  logic               timeout;
  logic               done_q, err_q;

  assign opc = instr_q[INSTR_W-1 -: OPC_W];

  cu_decode #(.OPC_W(OPC_W)) u_decode (
    .opc  (opc),
    .ctrl (ctrl)
  );

`ifdef MULTICYCLE_CONTROL_MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] mem_cnt;

  // Counts completed MEM cycles; restarts every time MEM is entered.
  always_ff @(posedge clk) begin
    if (!rst_n || state != MEM) mem_cnt <= '0;
    else                        mem_cnt <= mem_cnt + 1'b1;
  end

  assign timeout = (state == MEM) && !mem_ack && (mem_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      IDLE: if (instr_valid) state_nxt = EXEC;
      EXEC: begin
        if (ctrl.to_mem)     state_nxt = MEM;
        else if (ctrl.to_wb) state_nxt = WB;
        else begin
          state_nxt = IDLE;
          retire    = 1'b1;
        end
      end
      // An acknowledge in the last allowed cycle still wins over the timeout.
      MEM: begin
        if (mem_ack) begin
          if (ctrl.mem_rd) state_nxt = WB;
          else begin
            state_nxt = IDLE;
            retire    = 1'b1;
          end
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      WB: begin
        state_nxt = IDLE;
        retire    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      instr_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= retire;
      err_q  <= timeout;
      if (state == IDLE && instr_valid) instr_q <= instr;
    end
  end

  assign instr_ready  = (state == IDLE);
  assign mem_r_en     = (state == MEM) && ctrl.mem_rd;
  assign mem_w_en     = (state == MEM) && ctrl.mem_wr;
  assign reg_w_en     = (state == WB);
  assign sel_w_source = (state == WB) ? ctrl.wb_sel : SEL_ALU;
  assign pc_load      = (state == EXEC) &&
                        (ctrl.jump || (ctrl.br_eq && alu_zero) || (ctrl.br_ne && !alu_zero));
  assign alu_op       = opc;
  assign reg_addr_0   = instr_q[RA_W-1:0];
  assign reg_addr_1   = instr_q[2*RA_W-1:RA_W];
  assign reg_addr_w   = ctrl.wb_rd0 ? '0 : instr_q[2*RA_W-1:RA_W];
  assign done         = done_q;
  assign err          = err_q;

endmodule
